worker_result_arbiter: RTL

Collects worker results from NUM_WORKERS parallel workers and delivers them, one at a time, to the dispatcher's worker-result input port. It is the transmitting end of that valid/ready link. Round-robin arbitration picks among the requesting workers, and a small FIFO decouples the workers from dispatcher back-pressure. Results pass through unmodified: no reordering within a worker, and nothing is dropped.

---
 rtl/worker_result_arbiter.sv | 94 +++++++++
 1 files changed

// File: rtl/worker_result_arbiter.sv
// Round-robin collector of per-worker results into a small FIFO feeding the
// dispatcher's worker-result valid/ready input.
module worker_result_arbiter #(
    parameter int         NUM_WORKERS         = 4,
    parameter int         WORKER_RESULT_WIDTH = 98,
    parameter int         FIFO_DEPTH          = 4,
    parameter int         FIFO_ADDR_WIDTH     = 2,
    parameter logic [2:0] DEST_OPTION_END     = 3'd7
) (
    input  logic                                       CLK,
    input  logic                                       RST_N,
    input  logic [NUM_WORKERS-1:0]                     RECEIVE_WR_VALID,
    input  logic [NUM_WORKERS*WORKER_RESULT_WIDTH-1:0] RECEIVE_WR_DATA,
    output logic [NUM_WORKERS-1:0]                     RECEIVE_WR_READY,
    output logic                                       SEND_WR_VALID,
    output logic [WORKER_RESULT_WIDTH-1:0]             SEND_WR_DATA,
    input  logic                                       SEND_WR_READY,
    output logic [FIFO_ADDR_WIDTH:0]                   FIFO_COUNT,
    output logic                                       END_SEEN,
    output logic                                       IDLE
);

    localparam int IDX_W = $clog2(NUM_WORKERS);
    localparam logic [FIFO_ADDR_WIDTH:0] DEPTH_CNT = (FIFO_ADDR_WIDTH+1)'(FIFO_DEPTH);

    logic [NUM_WORKERS-1:0][WORKER_RESULT_WIDTH-1:0] wr_data;
    logic [WORKER_RESULT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0]     wr_ptr, rd_ptr;
    logic [FIFO_ADDR_WIDTH:0]       count;
    logic [IDX_W-1:0]               rr, grant, cand;
    logic                           grant_vld, push, pop, full;

    assign wr_data = RECEIVE_WR_DATA;

    // Search starts just after the last granted worker, so a worker that was
    // just served has the lowest priority next time.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_WORKERS; k++) begin
            cand = IDX_W'((int'(rr) + k) % NUM_WORKERS);
            if (!grant_vld && RECEIVE_WR_VALID[cand]) begin
                grant     = cand;
                grant_vld = 1'b1;
            end
        end
    end

    // Full is taken from registered count, so a pop never frees a slot for
    // a push in the same cycle.
    assign full = (count == DEPTH_CNT);
    assign push = RST_N && grant_vld && !full;
    assign pop  = SEND_WR_VALID && SEND_WR_READY;

    always_comb begin
        RECEIVE_WR_READY = '0;
        if (push)
            RECEIVE_WR_READY[grant] = 1'b1;
    end

    assign SEND_WR_VALID = (count != '0);
    assign SEND_WR_DATA  = mem[rd_ptr];
    assign FIFO_COUNT    = count;
    assign IDLE          = (count == '0) && !(|RECEIVE_WR_VALID);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rr       <= IDX_W'(NUM_WORKERS - 1);
            END_SEEN <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data[grant];
                wr_ptr      <= wr_ptr + FIFO_ADDR_WIDTH'(1);
                rr          <= grant;
            end
            if (pop)
                rd_ptr <= rd_ptr + FIFO_ADDR_WIDTH'(1);
            case ({push, pop})
                2'b10:   count <= count + (FIFO_ADDR_WIDTH+1)'(1);
                2'b01:   count <= count - (FIFO_ADDR_WIDTH+1)'(1);
                default: count <= count;
            endcase
            END_SEEN <= push &&
                (wr_data[grant][WORKER_RESULT_WIDTH-1 -: 3] == DEST_OPTION_END);
        end
    end

endmodule
